// File: rtl/aes_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_uart_pkg
// Description : Shared state encoding, command bytes and frame constants for
//               the AES/UART command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_uart_pkg;

    localparam int FRAME_W = 144;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_AES_LD   = 3'd2,
        ST_AES_WAIT = 3'd3,
        ST_TX_REQ   = 3'd4
    } state_t;

    localparam logic [1:0] FMT_DATA = 2'd0;
    localparam logic [1:0] FMT_ERR  = 2'd1;
    localparam logic [1:0] FMT_TEST = 2'd2;

    localparam logic [7:0] CMD_KEY   = 8'h43;  // 'C'
    localparam logic [7:0] CMD_TEXT  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_ENC   = 8'h45;  // 'E'
    localparam logic [7:0] CMD_RES   = 8'h40;  // '@'
    localparam logic [7:0] CMD_RDKEY = 8'h61;  // 'a'
    localparam logic [7:0] CMD_RDTXT = 8'h62;  // 'b'
    localparam logic [7:0] CMD_TEST  = 8'h41;  // 'A'
    localparam logic [7:0] CMD_ERR   = 8'h21;  // '!'

    localparam logic [7:0] ERR_UNKNOWN = 8'h01;
    localparam logic [7:0] ERR_TIMEOUT = 8'h02;

    // Byte 0 sits in the LSBs, so the string is stored reversed to read
    // "123456789012345678" on the wire.
    localparam logic [FRAME_W-1:0] TEST_FRAME = "876543210987654321";

endpackage
`default_nettype wire

// File: rtl/aes_uart_frame_fmt.sv
`default_nettype none
// ============================================================================
// Module      : aes_uart_frame_fmt
// Description : Combinational builder for data, error and test response frames.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_uart_frame_fmt
    import aes_uart_pkg::*;
(
    input  logic [1:0]         kind,
    input  logic [7:0]         cmd,
    input  logic [127:0]       payload,
    input  logic [7:0]         err_code,
    output logic [FRAME_W-1:0] frame
);

    always_comb begin
        frame = '0;
        case (kind)
            FMT_DATA: frame = {cmd, payload, cmd};
            FMT_ERR:  frame = {CMD_ERR, 112'h0, err_code, cmd, CMD_ERR};
            FMT_TEST: frame = TEST_FRAME;
            default:  frame = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aes_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_uart_cmd_sequencer
// Description : Validates UART command frames, sequences the AES core and
//               issues single-transaction response frames.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_uart_cmd_sequencer
    import aes_uart_pkg::*;
#(
    parameter int           FRAME_BYTES = 18,
    parameter logic [127:0] KEY_INIT    = 128'h0,
    parameter logic [127:0] TEXT_INIT   = 128'h0,
    parameter int           AES_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [FRAME_BYTES*8-1:0] rx_frame,
    output logic                     rx_ready,
    output logic [127:0]             aes_key,
    output logic [127:0]             aes_text,
    output logic                     aes_ld,
    input  logic                     aes_done,
    input  logic [127:0]             aes_result,
    output logic [FRAME_BYTES*8-1:0] tx_frame,
    output logic                     tx_send,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [7:0]               err_count
);

    localparam int                 c_CNT_W   = $clog2(AES_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(AES_TIMEOUT);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [FRAME_W-1:0]       r_rx;
    logic [FRAME_W-1:0]       r_tx_frame;
    logic [127:0]             r_key;
    logic [127:0]             r_text;
    logic [127:0]             r_result;
    logic [7:0]               r_err;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [1:0]               w_fmt_kind;
    logic [7:0]               w_fmt_cmd;
    logic [127:0]             w_fmt_payload;
    logic [7:0]               w_fmt_code;
    logic [FRAME_W-1:0]       w_fmt_frame;
    logic                     w_tx_load;
    logic                     w_err_inc;
    logic                     w_key_load;
    logic                     w_text_load;
    logic                     w_result_load;
    logic                     w_timeout;
    logic [7:0]               w_cmd;

    assign w_cmd     = r_rx[7:0];
    assign w_timeout = (r_cnt + c_CNT_W'(1)) == c_CNT_MAX;

    always_comb begin
        w_state_next  = r_state;
        aes_ld        = 1'b0;
        w_fmt_kind    = FMT_DATA;
        w_fmt_cmd     = w_cmd;
        w_fmt_payload = r_rx[135:8];
        w_fmt_code    = ERR_UNKNOWN;
        w_tx_load     = 1'b0;
        w_err_inc     = 1'b0;
        w_key_load    = 1'b0;
        w_text_load   = 1'b0;
        w_result_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_cmd != r_rx[143:136]) begin
                    w_err_inc    = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_TX_REQ;
                    w_tx_load    = 1'b1;
                    case (w_cmd)
                        CMD_KEY: begin
                            w_key_load   = 1'b1;
                            w_tx_load    = 1'b0;
                            w_state_next = ST_IDLE;
                        end
                        CMD_TEXT: begin
                            w_text_load  = 1'b1;
                            w_tx_load    = 1'b0;
                            w_state_next = ST_IDLE;
                        end
                        CMD_ENC: begin
                            w_tx_load    = 1'b0;
                            w_state_next = ST_AES_LD;
                        end
                        CMD_RES:   w_fmt_payload = r_result;
                        CMD_RDKEY: w_fmt_payload = r_key;
                        CMD_RDTXT: w_fmt_payload = r_text;
                        CMD_TEST:  w_fmt_kind    = FMT_TEST;
                        default: begin
                            w_fmt_kind = FMT_ERR;
                            w_err_inc  = 1'b1;
                        end
                    endcase
                end
            end
            ST_AES_LD: begin
                aes_ld       = 1'b1;
                w_state_next = ST_AES_WAIT;
            end
            ST_AES_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (aes_done) begin
                    w_result_load = 1'b1;
                    w_fmt_cmd     = CMD_ENC;
                    w_fmt_payload = aes_result;
                    w_tx_load     = 1'b1;
                    w_state_next  = ST_TX_REQ;
                end else if (w_timeout) begin
                    w_fmt_kind   = FMT_ERR;
                    w_fmt_code   = ERR_TIMEOUT;
                    w_err_inc    = 1'b1;
                    w_tx_load    = 1'b1;
                    w_state_next = ST_TX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (tx_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    aes_uart_frame_fmt u_frame_fmt (
        .kind     (w_fmt_kind),
        .cmd      (w_fmt_cmd),
        .payload  (w_fmt_payload),
        .err_code (w_fmt_code),
        .frame    (w_fmt_frame)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rx       <= '0;
            r_tx_frame <= '0;
            r_key      <= KEY_INIT;
            r_text     <= TEXT_INIT;
            r_result   <= '0;
            r_err      <= 8'd0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && rx_valid) r_rx <= rx_frame;
            if (w_tx_load)     r_tx_frame <= w_fmt_frame;
            if (w_key_load)    r_key      <= r_rx[135:8];
            if (w_text_load)   r_text     <= r_rx[135:8];
            if (w_result_load) r_result   <= aes_result;
            if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (r_state == ST_AES_LD)        r_cnt <= '0;
            else if (r_state == ST_AES_WAIT) r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Gated by reset so the block reports not-ready while held in reset.
    assign rx_ready  = (r_state == ST_IDLE) && !reset;
    assign tx_send   = (r_state == ST_TX_REQ) && tx_ready;
    assign busy      = (r_state != ST_IDLE);
    assign tx_frame  = r_tx_frame;
    assign aes_key   = r_key;
    assign aes_text  = r_text;
    assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_uart_cmd_sequencer
// Description : Scoreboard bench for the AES/UART command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_uart_cmd_sequencer;

    localparam logic [127:0] c_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_valid;
    logic [143:0] rx_frame;
    logic         rx_ready;
    logic [127:0] aes_key;
    logic [127:0] aes_text;
    logic         aes_ld;
    logic         aes_done;
    logic [127:0] aes_result;
    logic [143:0] tx_frame;
    logic         tx_send;
    logic         tx_ready;
    logic         busy;
    logic [7:0]   err_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int ld_count = 0;
    int tx_count = 0;
    int last_ld_cyc = 0;
    int last_tx_cyc = 0;
    int done_cyc = 0;
    int core_cnt = 0;
    logic core_busy = 1'b0;
    logic core_en = 1'b1;
    logic [143:0] exp_q[$];

    aes_uart_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_frame   (rx_frame),
        .rx_ready   (rx_ready),
        .aes_key    (aes_key),
        .aes_text   (aes_text),
        .aes_ld     (aes_ld),
        .aes_done   (aes_done),
        .aes_result (aes_result),
        .tx_frame   (tx_frame),
        .tx_send    (tx_send),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // AES core model: done is seen on the 21st clock edge after aes_ld.
    always @(negedge clk) begin
        aes_done = 1'b0;
        if (reset) begin
            core_busy = 1'b0;
        end else if (aes_ld) begin
            core_busy = 1'b1;
            core_cnt  = 0;
        end else if (core_busy) begin
            core_cnt = core_cnt + 1;
            if (core_en && core_cnt == 21) begin
                aes_done   = 1'b1;
                aes_result = c_CT;
                done_cyc   = cyc;
                core_busy  = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted response.
    always @(negedge clk) begin
        if (aes_ld) begin
            ld_count    = ld_count + 1;
            last_ld_cyc = cyc;
        end
        if (tx_send) begin
            tx_count    = tx_count + 1;
            last_tx_cyc = cyc;
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_tx: got %h, expected no response", tx_frame);
            end else begin
                logic [143:0] e;
                e = exp_q.pop_front();
                if (tx_frame !== e) begin
                    n_err = n_err + 1;
                    $display("FAIL tx_frame: got %h, expected %h", tx_frame, e);
                end
            end
            n_cmp = n_cmp + 1;
            if (aes_ld !== 1'b0) begin
                n_err = n_err + 1;
                $display("FAIL ld_send_overlap: aes_ld %b, expected 0", aes_ld);
            end
        end
    end

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] data_frame(input logic [7:0] c, input logic [127:0] p);
        logic [143:0] f;
        f = '0;
        f[7:0]     = c;
        f[135:8]   = p;
        f[143:136] = c;
        return f;
    endfunction

    function automatic logic [143:0] err_frame(input logic [7:0] c, input logic [7:0] code);
        logic [143:0] f;
        f = '0;
        f[7:0]     = 8'h21;
        f[15:8]    = c;
        f[23:16]   = code;
        f[143:136] = 8'h21;
        return f;
    endfunction

    task automatic send(input logic [7:0] c0, input logic [127:0] p, input logic [7:0] c17);
        int t;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_frame = {c17, p, c0};
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("rx_accept_timeout", 144'(rx_ready), 144'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("idle_timeout", 144'(busy), 144'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  144'(rx_ready),  144'd0);
        check({tag, "_aes_ld"},    144'(aes_ld),    144'd0);
        check({tag, "_tx_send"},   144'(tx_send),   144'd0);
        check({tag, "_busy"},      144'(busy),      144'd0);
        check({tag, "_err_count"}, 144'(err_count), 144'd0);
        check({tag, "_tx_frame"},  tx_frame,        144'd0);
        check({tag, "_aes_key"},   144'(aes_key),   144'd0);
        check({tag, "_aes_text"},  144'(aes_text),  144'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [143:0] tf;
        int ld_before, tx_before, bad;

        reset = 1'b1; rx_valid = 1'b0; rx_frame = '0; tx_ready = 1'b1;
        aes_result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1; reset = 1'b0;

        // Key load, then read back
        send(8'h43, c_KEY, 8'h43);
        wait_idle();
        check("key_loaded", 144'(aes_key), 144'(c_KEY));
        exp_q.push_back(data_frame(8'h61, c_KEY));
        send(8'h61, 128'h0, 8'h61);
        wait_idle();

        // Plaintext, encrypt, result read
        send(8'h44, c_PT, 8'h44);
        wait_idle();
        check("text_loaded", 144'(aes_text), 144'(c_PT));
        ld_before = ld_count;
        exp_q.push_back(data_frame(8'h45, c_CT));
        send(8'h45, 128'h0, 8'h45);
        wait_idle();
        check("enc_ld_pulses", 144'(ld_count - ld_before), 144'd1);
        check("enc_done_latency_ok",
              144'((last_tx_cyc - done_cyc >= 1) && (last_tx_cyc - done_cyc <= 2)), 144'd1);
        exp_q.push_back(data_frame(8'h40, c_CT));
        send(8'h40, 128'h0, 8'h40);
        wait_idle();

        // Test string
        s = "123456789012345678";
        tf = '0;
        for (int i = 0; i < 18; i++) tf[i*8 +: 8] = s[i];
        exp_q.push_back(tf);
        send(8'h41, 128'h0, 8'h41);
        wait_idle();

        // Broken framing: dropped, counted, key untouched
        tx_before = tx_count;
        send(8'h43, 128'hdeadbeef_00000000_11111111_22222222, 8'h44);
        wait_idle();
        check("badframe_key", 144'(aes_key), 144'(c_KEY));
        check("badframe_err", 144'(err_count), 144'd1);
        check("badframe_no_tx", 144'(tx_count - tx_before), 144'd0);

        // Unknown command
        exp_q.push_back(err_frame(8'h5A, 8'h01));
        send(8'h5A, 128'h0, 8'h5A);
        wait_idle();
        check("unknown_err", 144'(err_count), 144'd2);

        // Timeout: response 64 WAIT cycles after entry (WAIT begins after aes_ld)
        core_en = 1'b0;
        exp_q.push_back(err_frame(8'h45, 8'h02));
        send(8'h45, 128'h0, 8'h45);
        wait_idle();
        check("timeout_latency", 144'(last_tx_cyc - last_ld_cyc), 144'd65);
        check("timeout_err", 144'(err_count), 144'd3);
        exp_q.push_back(data_frame(8'h62, c_PT));
        send(8'h62, 128'h0, 8'h62);
        wait_idle();

        // Back-pressure on TX
        tx_ready = 1'b0;
        tx_before = tx_count;
        exp_q.push_back(data_frame(8'h61, c_KEY));
        send(8'h61, 128'h0, 8'h61);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_send !== 1'b0 || rx_ready !== 1'b0) bad = bad + 1;
        end
        check("backpressure_hold", 144'(bad), 144'd0);
        @(posedge clk); #1; tx_ready = 1'b1;
        @(negedge clk);
        #1;
        check("backpressure_release", 144'(tx_count - tx_before), 144'd1);
        wait_idle();

        // Reset while waiting on the core
        send(8'h45, 128'h0, 8'h45);
        repeat (10) @(posedge clk);
        #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk); #1; reset = 1'b0;
        core_en = 1'b1;
        tx_before = tx_count;
        repeat (100) @(negedge clk);
        check("midreset_no_tx", 144'(tx_count - tx_before), 144'd0);
        check("scoreboard_empty", 144'(exp_q.size()), 144'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
